// File: rtl/adxl362_pkg.sv
// Shared constants for the ADXL362 register-interface responder.
// Command codes, register map, fixed IDs and FSM state encoding.
`timescale 1ns/1ps
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;

  localparam logic [7:0] ADDR_DEVID_AD  = 8'h00;
  localparam logic [7:0] ADDR_DEVID_MST = 8'h01;
  localparam logic [7:0] ADDR_PARTID    = 8'h02;
  localparam logic [7:0] ADDR_REVID     = 8'h03;
  localparam logic [7:0] ADDR_XDATA_L   = 8'h0E;
  localparam logic [7:0] ADDR_XDATA_H   = 8'h0F;
  localparam logic [7:0] ADDR_YDATA_L   = 8'h10;
  localparam logic [7:0] ADDR_YDATA_H   = 8'h11;
  localparam logic [7:0] ADDR_ZDATA_L   = 8'h12;
  localparam logic [7:0] ADDR_ZDATA_H   = 8'h13;
  localparam logic [7:0] ADDR_POWER_CTL = 8'h2D;

  localparam logic [7:0] DEVID_AD_VAL  = 8'hAD;
  localparam logic [7:0] DEVID_MST_VAL = 8'h1D;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_ADDR_W = 3'd2;
  localparam state_t ST_ADDR_R = 3'd3;
  localparam state_t ST_WRITE  = 3'd4;
  localparam state_t ST_READ   = 3'd5;
  localparam state_t ST_IGNORE = 3'd6;

endpackage

// File: rtl/adxl362_spi_responder_sync.sv
// Two-flop synchronizer with registered-history edge detect.
// Rise/fall pulses are one clk_i cycle wide.
`timescale 1ns/1ps
module spi_sync_edge (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/adxl362_spi_responder.sv
// SPI mode-0 peripheral emulating the ADXL362 register interface.
// Samples are snapshotted per CS frame; POWER_CTL is exported.
`timescale 1ns/1ps
module adxl362_spi_responder
  import adxl362_pkg::*;
#(
  parameter int unsigned    p_clkfreq = 100_000_000,
  parameter logic [7:0]     p_partid  = 8'hF2,
  parameter logic [7:0]     p_revid   = 8'h01
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sclk_i,
  input  logic        cs_i,
  input  logic        mosi_i,
  output logic        miso_o,
  input  logic [15:0] ax_i,
  input  logic [15:0] ay_i,
  input  logic [15:0] az_i,
  output logic [7:0]  power_ctl_o,
  output logic        measure_o,
  output logic        wr_strobe_o,
  output logic [7:0]  wr_addr_o
);

  if (p_clkfreq < 32'd8) begin : g_bad_clk
    $error("p_clkfreq too low");
  end

  // Sync regs reset low so a frame in flight at reset release
  // produces no CS fall and is ignored until CS cycles.
  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_meta_q, mosi_s_q;

  spi_sync_edge u_sclk (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (sclk_i),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge u_cs (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (cs_i),
    .sync_o (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mosi_meta_q <= 1'b0;
      mosi_s_q    <= 1'b0;
    end else begin
      mosi_meta_q <= mosi_i;
      mosi_s_q    <= mosi_meta_q;
    end
  end

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [47:0] shadow_q, shadow_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic        measure_q, measure_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [7:0]  wr_addr_q, wr_addr_d;

  logic [7:0]  rx_next;
  logic        byte_done;
  logic [7:0]  rd_addr;
  logic [7:0]  rd_data;

  assign rx_next   = {rx_q[6:0], mosi_s_q};
  assign byte_done = sclk_rise & (bit_cnt_q == 3'd7);
  assign rd_addr   = (state_q == ST_ADDR_R) ? rx_next
                                            : addr_q + 8'd1;

  always_comb begin
    rd_data = 8'h00;
    unique case (rd_addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD_VAL;
      ADDR_DEVID_MST: rd_data = DEVID_MST_VAL;
      ADDR_PARTID:    rd_data = p_partid;
      ADDR_REVID:     rd_data = p_revid;
      ADDR_XDATA_L:   rd_data = shadow_q[7:0];
      ADDR_XDATA_H:   rd_data = shadow_q[15:8];
      ADDR_YDATA_L:   rd_data = shadow_q[23:16];
      ADDR_YDATA_H:   rd_data = shadow_q[31:24];
      ADDR_ZDATA_L:   rd_data = shadow_q[39:32];
      ADDR_ZDATA_H:   rd_data = shadow_q[47:40];
      ADDR_POWER_CTL: rd_data = power_ctl_q;
      default:        rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    addr_d      = addr_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    shadow_d    = shadow_q;
    power_ctl_d = power_ctl_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    measure_d   = (power_ctl_q[1:0] == 2'b10);

    // CS rise takes priority, dropping any byte finishing now
    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
    end else if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      miso_d    = 1'b0;
      shadow_d  = {az_i, ay_i, ax_i};
    end else if (state_q != ST_IDLE && !cs_s) begin
      if (sclk_rise) begin
        rx_d      = rx_next;
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      if (sclk_fall) begin
        if (state_q == ST_READ) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else begin
          miso_d = 1'b0;
        end
      end
      if (byte_done) begin
        case (state_q)
          ST_CMD: begin
            if (rx_next == CMD_WRITE)
              state_d = ST_ADDR_W;
            else if (rx_next == CMD_READ)
              state_d = ST_ADDR_R;
            else
              state_d = ST_IGNORE;
          end
          ST_ADDR_W: begin
            addr_d  = rx_next;
            state_d = ST_WRITE;
          end
          ST_ADDR_R: begin
            addr_d  = rx_next;
            tx_d    = rd_data;
            state_d = ST_READ;
          end
          ST_WRITE: begin
            wr_strobe_d = 1'b1;
            wr_addr_d   = addr_q;
            if (addr_q == ADDR_POWER_CTL)
              power_ctl_d = rx_next;
            addr_d = addr_q + 8'd1;
          end
          ST_READ: begin
            addr_d = addr_q + 8'd1;
            tx_d   = rd_data;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      addr_q      <= 8'h00;
      tx_q        <= 8'h00;
      miso_q      <= 1'b0;
      shadow_q    <= 48'h0;
      power_ctl_q <= 8'h00;
      measure_q   <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      addr_q      <= addr_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      shadow_q    <= shadow_d;
      power_ctl_q <= power_ctl_d;
      measure_q   <= measure_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign miso_o      = miso_q;
  assign power_ctl_o = power_ctl_q;
  assign measure_o   = measure_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;

  logic unused_sclk;
  assign unused_sclk = sclk_s;

endmodule

// File: doc/adxl362_spi_responder.md
# adxl362_spi_responder

Synthesizable SPI peripheral that emulates the ADXL362 accelerometer register interface. It sits at the far end of the SPI bus from the accelerometer controller and is used in on-board loopback builds and simulation benches in place of the physical sensor. It decodes write (0x0A) and read (0x0B) commands with an address and auto-incremented burst data. Acceleration samples are supplied from fabric, and POWER_CTL state is exposed to fabric.

## Interface
- p_clkfreq, 100_000_000: system clock frequency (Hz); must be ≥ 8 × SCLK frequency.
- p_partid, 8'hF2: value returned at address 0x02.
- p_revid, 8'h01: value returned at address 0x03.
- clk_i  in  1  system clock; all logic is synchronous to its rising edge.
- rstn_i  in  1  asynchronous, active-low reset.
- sclk_i  in  1  SPI clock from the controller (mode 0, CPOL=0/CPHA=0); asynchronous to clk_i.
- cs_i  in  1  chip select, active low; asynchronous.
- mosi_i  in  1  controller-to-peripheral data, MSB first.
- miso_o  out  1  peripheral-to-controller data, MSB first; 0 when not driving read data.
- ax_i, ay_i, az_i  in  16 each  acceleration sample presented by fabric.
- power_ctl_o  out  8  POWER_CTL register (address 0x2D).
- measure_o  out  1  high when power_ctl_o[1:0] == 2'b10.
- wr_strobe_o  out  1  one-cycle pulse per completed register write byte.
- wr_addr_o  out  8  address of the last completed write; valid with wr_strobe_o.

## Operation
- sclk_i, cs_i, and mosi_i each pass through 2-FF synchronizers. Edges of SCLK and CS are detected on the synchronized signals.
- CS falling edge: snapshot ax_i/ay_i/az_i into 48-bit shadow, clear bit counter, state ← CMD.
- CS rising edge, any state: state ← IDLE. A partial byte is discarded; no write occurs and the address is not incremented.
- SCLK rising edge with CS low: shift the synchronized MOSI into the receive byte. The 8th rising edge completes the byte.
- SCLK falling edge with CS low: shift the next transmit bit onto miso_o.
- States:
  - IDLE: wait for CS falling edge.
  - CMD: on byte complete, 0x0A → ADDR_W, 0x0B → ADDR_R, any other value → IGNORE.
  - ADDR_W: on byte complete, latch address → WRITE.
  - ADDR_R: on byte complete, latch address, load the transmit byte from the address → READ.
  - WRITE: on byte complete, write to the latched address, pulse wr_strobe_o, address + 1.
  - READ: on byte complete, address + 1 and load the transmit byte from the new address.
  - IGNORE: consume bytes; miso_o stays 0.
- Read map:
  - 0x00 = 8'hAD, 0x01 = 8'h1D, 0x02 = p_partid, 0x03 = p_revid.
  - 0x0E..0x13 = shadow X_L, X_H, Y_L, Y_H, Z_L, Z_H.
  - 0x2D = power_ctl_o.
  - All other addresses read 8'h00.
- Write map: only 0x2D is writable. Writes to other addresses still pulse wr_strobe_o but change no state.
- Address is 8 bits and wraps 0xFF → 0x00.

## Timing
- Reset values: miso_o=0, power_ctl_o=8'h00, measure_o=0, wr_strobe_o=0, wr_addr_o=8'h00, state=IDLE, shadow=0.
- Reset asserted mid-transaction: immediate return to IDLE with reset values. The remainder of that CS frame is ignored until the next CS falling edge.
- SCLK/CS edge-to-action latency: 3 clk_i cycles (2 sync + 1 edge detect).
- MISO MSB of each read byte is driven within 3 clk_i cycles of the 8th SCLK falling edge of the preceding byte. It must therefore be stable before the next rising edge. This holds for SCLK ≤ p_clkfreq/8.
- wr_strobe_o and the power_ctl_o update occur in the same clk_i cycle, 3 cycles after the 8th rising edge of the data byte.
- measure_o is registered from power_ctl_o: 1 cycle later.
- Sample snapshot is taken once per CS frame. Changes to ax_i during a frame are not visible until the next frame.
- A CS rising edge and an 8th SCLK rising edge in the same detect cycle: CS wins, and the byte is discarded.

## Structure
- Shared package adxl362_pkg holds:
  - command constants CMD_WRITE=8'h0A, CMD_READ=8'h0B;
  - register addresses (DEVID_AD, DEVID_MST, PARTID, REVID, XDATA_L..ZDATA_H, POWER_CTL);
  - fixed ID values;
  - the state enum.
- One sub-module, spi_sync_edge: 2-FF synchronizer plus rise/fall pulse output, instantiated for sclk_i and cs_i. mosi_i uses the synchronizer path only.

## Test plan
- Reset: hold rstn_i low, toggle SCLK/CS → all outputs at reset values, miso_o=0.
- Config write 0A 2D 02 at SCLK=1 MHz → power_ctl_o=8'h02, measure_o=1, wr_strobe_o exactly one pulse with wr_addr_o=8'h2D.
- Burst read 0B 0E 00×6 with ax=16'h1234, ay=16'hABCD, az=16'hFFFE → MISO bytes 34 12 CD AB FE FF. Changing ax_i mid-frame does not alter the bytes.
- ID read 0B 00 00×4 → AD 1D F2 01. Read 0B FF 00×2 → 00 (0xFF), AD (wrapped to 0x00).
- CS deasserted after 5 bits of the data byte in 0A 2D xx → power_ctl_o unchanged, no wr_strobe_o. The next full 0A 2D 00 frame writes 00.
- Unknown command 0D followed by 3 bytes → miso_o=0 throughout, no writes. rstn_i pulsed low mid-read → IDLE; the next frame decodes correctly.
